// File: rtl/reg_bank_dump.sv
// 32-entry integer register bank with two combinational read ports and a
// snapshot-based debug dump engine that streams every register over valid/ready.
module reg_bank_dump #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(32'h0000_0FFC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       en_s,
    input  logic [DATA_W-1:0] data_wr,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    output logic [DATA_W-1:0] ru_rs1,
    output logic [DATA_W-1:0] ru_rs2,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [4:0]        dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'd31;

    // x0 is hardwired to zero, so only x1..x31 are stored.
    logic [DATA_W-1:0] regs_q [1:31];
    logic [DATA_W-1:0] regs_d [1:31];

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [4:0]        nxt_idx;
    logic              unused_en0;

    assign unused_en0 = en_s[0];
    assign nxt_idx    = idx_q + 5'd1;

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 32; i++) begin
            if (en_s[i]) begin
                regs_d[i] = data_wr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= (i == 2) ? SP_RESET : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports see only the stored array; a same-edge write appears next cycle.
    assign ru_rs1 = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    assign ru_rs2 = (rs2 == 5'd0) ? '0 : regs_q[rs2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dump_start) state_d = SEND;
            SEND:    if (dump_ready && idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The next beat is loaded from the pre-edge array, so a write landing on the
    // handshake edge or during a stall never alters the beat being offered.
    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    idx_d  = '0;
                    data_d = '0;
                end
            end
            SEND: begin
                if (dump_ready && idx_q != LAST_IDX) begin
                    idx_d  = nxt_idx;
                    data_d = regs_q[nxt_idx];
                end
            end
            DONE: begin
                idx_d  = '0;
                data_d = '0;
            end
            default: begin
                idx_d  = '0;
                data_d = '0;
            end
        endcase
    end

    always_comb begin
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        case (state_q)
            SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
            end
            DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign dump_idx  = idx_q;
    assign dump_data = data_q;

endmodule

// File: tb/tb_reg_bank_dump.sv
// Bench for reg_bank_dump: directed steps plus randomized traffic, checked against
// an array-based model of the register file and the dump's snapshot rules.
module tb_reg_bank_dump;

    localparam logic [31:0] SP = 32'h0000_0FFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] en_s;
    logic [31:0] data_wr;
    logic [4:0]  rs1, rs2;
    logic [31:0] ru_rs1, ru_rs2;
    logic        dump_start, dump_busy, dump_valid, dump_ready, dump_done;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] mreg [32];
    int          m_phase;
    int          m_idx;
    logic [31:0] m_data;

    reg_bank_dump #(.DATA_W(32), .SP_RESET(SP)) dut (
        .clk(clk), .rst_n(rst_n), .en_s(en_s), .data_wr(data_wr),
        .rs1(rs1), .rs2(rs2), .ru_rs1(ru_rs1), .ru_rs2(ru_rs2),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        mreg[2] = SP;
        m_phase = 0;
        m_idx   = 0;
        m_data  = 32'h0;
    endtask

    // Applies the effect of the coming clock edge to the model, then advances past it.
    task automatic tick();
        logic [31:0] pre [32];
        pre = mreg;
        for (int i = 1; i < 32; i++) if (en_s[i]) mreg[i] = data_wr;
        case (m_phase)
            0: if (dump_start) begin m_phase = 1; m_idx = 0; m_data = 32'h0; end
            1: if (dump_ready) begin
                   if (m_idx == 31) m_phase = 2;
                   else begin m_idx++; m_data = pre[m_idx]; end
               end
            default: begin m_phase = 0; m_idx = 0; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        #1;
        chk("rd1", ru_rs1, mreg[rs1]);
        chk("rd2", ru_rs2, mreg[rs2]);
        chk("valid", 32'(dump_valid), 32'(m_phase == 1));
        chk("busy", 32'(dump_busy), 32'(m_phase != 0));
        chk("done", 32'(dump_done), 32'(m_phase == 2));
        if (m_phase == 1) begin
            chk("idx", 32'(dump_idx), 32'(m_idx));
            chk("data", dump_data, m_data);
        end else if (m_phase == 0) begin
            chk("idle_idx", 32'(dump_idx), 32'h0);
        end
    endtask

    initial begin
        int          beats, busy_n, done_n, iters;
        logic [4:0]  seen [$];

        rst_n = 1'b1; en_s = '0; data_wr = '0; rs1 = '0; rs2 = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 rs1 = 5'd2; rs2 = 5'd5;
        #1;
        chk("rst_x2", ru_rs1, SP);
        chk("rst_x5", ru_rs2, 32'h0);
        chk("rst_valid", 32'(dump_valid), 32'h0);
        chk("rst_busy", 32'(dump_busy), 32'h0);
        chk("rst_done", 32'(dump_done), 32'h0);
        chk("rst_idx", 32'(dump_idx), 32'h0);
        chk("rst_data", dump_data, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Plain write/read and x0 protection
        en_s = 32'h1 << 7; data_wr = 32'hDEAD_BEEF; tick();
        en_s = '0; rs1 = 5'd7; #1;
        chk("wr_x7", ru_rs1, 32'hDEAD_BEEF);
        en_s = 32'h1; data_wr = 32'h5; tick();
        en_s = '0; rs1 = 5'd0; #1;
        chk("x0_zero", ru_rs1, 32'h0);
        check_all();

        for (int i = 1; i < 32; i++) begin
            en_s = 32'h1 << i; data_wr = 32'h100 + i; tick();
            en_s = '0; rs1 = 5'(i); #1;
            chk("preload", ru_rs1, 32'h100 + i);
        end

        // Full dump with ready tied high
        dump_start = 1'b1; dump_ready = 1'b1; tick(); dump_start = 1'b0;
        beats = 0; busy_n = 0; done_n = 0;
        for (int c = 0; c < 40; c++) begin
            check_all();
            if (dump_busy) busy_n++;
            if (dump_done) done_n++;
            if (dump_valid && dump_ready) begin
                chk("full_idx", 32'(dump_idx), 32'(beats));
                chk("full_data", dump_data, (beats == 0) ? 32'h0 : 32'h100 + beats);
                beats++;
            end
            tick();
        end
        chk("full_beats", 32'(beats), 32'd32);
        chk("full_busy_cycles", 32'(busy_n), 32'd33);
        chk("full_done_cycles", 32'(done_n), 32'd1);

        // Random backpressure with concurrent random writes and reads
        dump_start = 1'b1; tick(); dump_start = 1'b0;
        iters = 0;
        while (m_phase != 0 && iters < 400) begin
            dump_ready = 1'($urandom_range(0, 1));
            en_s = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            data_wr = $urandom;
            rs1 = 5'($urandom); rs2 = 5'($urandom);
            check_all();
            if (dump_valid && dump_ready) seen.push_back(dump_idx);
            tick();
            iters++;
        end
        en_s = '0;
        chk("bp_beats", 32'(seen.size()), 32'd32);
        for (int k = 0; k < seen.size(); k++) chk("bp_order", 32'(seen[k]), 32'(k));
        check_all();

        // Snapshot races: stall write to x4, handshake-edge write to x5
        en_s = 32'h1 << 4; data_wr = 32'h0404_0404; tick();
        en_s = 32'h1 << 5; data_wr = 32'h0505_0505; tick();
        en_s = '0;
        dump_start = 1'b1; dump_ready = 1'b1; tick(); dump_start = 1'b0;
        repeat (4) begin check_all(); tick(); end
        dump_ready = 1'b0; en_s = 32'h1 << 4; data_wr = 32'hAAAA_AAAA;
        check_all(); tick();
        en_s = '0; #1;
        chk("stall_idx", 32'(dump_idx), 32'd4);
        chk("stall_data", dump_data, 32'h0404_0404);
        chk("stall_valid", 32'(dump_valid), 32'h1);
        dump_ready = 1'b1; en_s = 32'h1 << 5; data_wr = 32'h5555_5555;
        check_all(); tick();
        en_s = '0; rs1 = 5'd5; #1;
        chk("race_idx", 32'(dump_idx), 32'd5);
        chk("race_data", dump_data, 32'h0505_0505);
        chk("race_x5_now", ru_rs1, 32'h5555_5555);
        iters = 0;
        while (m_phase != 0 && iters < 40) begin check_all(); tick(); iters++; end
        chk("race_finished", 32'(m_phase), 32'h0);
        check_all();

        // Reset in the middle of a dump
        dump_start = 1'b1; dump_ready = 1'b1; tick(); dump_start = 1'b0;
        repeat (10) begin check_all(); tick(); end
        #1 chk("pre_abort_idx", 32'(dump_idx), 32'd10);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(dump_valid), 32'h0);
        chk("abort_busy", 32'(dump_busy), 32'h0);
        chk("abort_done", 32'(dump_done), 32'h0);
        chk("abort_idx", 32'(dump_idx), 32'h0);
        chk("abort_data", dump_data, 32'h0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        rs1 = 5'd2; rs2 = 5'd10;
        repeat (5) begin check_all(); tick(); end
        chk("abort_x2", ru_rs1, SP);
        dump_start = 1'b1; tick(); dump_start = 1'b0; #1;
        chk("restart_idx", 32'(dump_idx), 32'h0);
        chk("restart_valid", 32'(dump_valid), 32'h1);
        iters = 0;
        while (m_phase != 0 && iters < 60) begin check_all(); tick(); iters++; end
        chk("restart_finished", 32'(m_phase), 32'h0);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_dump.md
Name: reg_bank_dump

Overview:
- 32 x DATA_W RISC-V integer register bank for the single-cycle core's Register Unit.
- Consumes the per-register write-enable one-hot produced by the 5-to-32 write decoder and provides two combinational read ports.
- Adds a sequential debug dump engine that streams all 32 registers out over a valid/ready handshake, for the board's UART/LED debug path.

Parameters:
- DATA_W, 32, register width in bits.
- SP_RESET, 32'h0000_0FFC, reset value of x2 (sp). All other registers reset to 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- en_s  in  32  one-hot write enable from the decoder. Bit 0 is always ignored.
- data_wr  in  DATA_W  write-back data.
- rs1  in  5  read address A.
- rs2  in  5  read address B.
- ru_rs1  out  DATA_W  register[rs1].
- ru_rs2  out  DATA_W  register[rs2].
- dump_start  in  1  request a full dump. Sampled only in IDLE.
- dump_busy  out  1  high from the cycle after start is accepted until DONE ends.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts the beat.
- dump_idx  out  5  register index of the current beat.
- dump_data  out  DATA_W  snapshot value of register dump_idx.
- dump_done  out  1  one-cycle pulse after the last beat.

Behaviour:
- Reset, asynchronous on rst_n low, takes effect immediately:
  - x2 = SP_RESET; all other registers = 0.
  - FSM = IDLE.
  - dump_busy = 0, dump_valid = 0, dump_idx = 0, dump_data = 0, dump_done = 0.
- Write: on the rising edge, register i <= data_wr for every i in 1..31 with en_s[i] = 1.
  - A multi-hot en_s writes all flagged registers; this is legal and not checked.
  - x0 is never stored.
- Read: ru_rs1 and ru_rs2 are combinational from the array, with no write-through bypass.
  - A write at edge t is visible on the read ports after t.
  - An address of 0 returns 0.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_start = 1 at edge t -> at t: state = SEND, dump_idx = 0, dump_data = x0 = 0, dump_valid = 1, dump_busy = 1.
  - SEND, handshake (dump_valid & dump_ready) at edge k with dump_idx < 31 -> at k: dump_idx + 1, and dump_data = array[dump_idx + 1] as it was before edge k.
  - A write at the same edge k is NOT captured; the pre-edge value is taken. This gives back-to-back beats, one per cycle, when dump_ready is held high.
  - SEND without a handshake: dump_idx and dump_data hold stable, and dump_valid stays 1. Writes to the array during the stall do not alter dump_data.
  - SEND, handshake with dump_idx = 31 -> state = DONE, dump_valid = 0, dump_done = 1.
  - DONE: lasts one cycle. Then IDLE, dump_done = 0, dump_busy = 0, dump_idx = 0.
- dump_start while busy is ignored; no queuing.
- dump_start held high continuously restarts a new dump on the first IDLE cycle.
- Normal register writes and reads are never stalled by the dump.
- rst_n asserted mid-dump aborts the dump: no dump_done pulse, and outputs go to reset values.
- A full dump with dump_ready tied high lasts 32 SEND cycles + 1 DONE cycle. dump_busy is high for 33 cycles.

Test Plan:
- Reset and read: deassert rst_n, read rs1=2, rs2=5 -> ru_rs1=32'h0000_0FFC, ru_rs2=0.
- Write/read and x0 protection:
  - en_s=1<<7, data_wr=32'hDEAD_BEEF -> next cycle rs1=7 reads DEAD_BEEF.
  - en_s=32'h1, data_wr=5 -> rs1=0 still reads 0.
- Full dump with dump_ready=1:
  - Preload x_i = 32'h100+i for i=1..31, pulse dump_start.
  - Expect 32 consecutive beats idx 0..31, data 0, 32'h101 .. 32'h11F.
  - Then dump_done high for exactly 1 cycle, and dump_busy high for 33 cycles.
- Backpressure: toggle dump_ready pseudo-randomly -> every beat transferred exactly once, in order, with idx/data stable while valid & !ready.
- Snapshot race:
  - Stall on idx 4 and write x4=32'hAAAA_AAAA -> beat 4 still carries the old value.
  - Handshake idx 4 at the same edge as writing x5=32'h5555_5555 -> beat 5 carries the old x5.
- Reset mid-dump: assert rst_n low at beat 10 -> dump_valid=0, dump_busy=0, no dump_done; x2 = SP_RESET afterwards. A new dump_start then restarts at idx 0.
